// File: rtl/cpu_mm_core.sv
`default_nettype none
// ==========================================================================
// cpu_mm_core : multi-cycle memory-to-memory CPU, variable-length
//               instructions, request/ack memory port, one level interrupt.
// Revision    : 1.0
// ==========================================================================
module cpu_mm_core #(
  parameter int            DW       = 32,
  parameter int            AW       = 32,
  parameter logic [AW-1:0] PC_RESET = '0,
  parameter logic [AW-1:0] IRQ_VEC  = AW'('h10)
) (
  input  logic          clk,
  input  logic          W_RST,
  input  logic          irq,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          retire,
  output logic          halted,
  output logic          illegal
);

  localparam int SHW = $clog2(DW);

  localparam logic [3:0] OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3,  OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5,  OP_NOT = 4'd6,  OP_SHL = 4'd7,  OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9,  OP_MOV = 4'd10, OP_JMP = 4'd11, OP_RETI = 4'd12;
  localparam logic [3:0] OP_HLT = 4'd13, OP_ADC = 4'd14, OP_ILL = 4'd15;

  typedef enum logic [3:0] {
    S_INIT, S_IFETCH, S_DECODE, S_OPFETCH, S_LOADA,
    S_LOADB, S_EXEC, S_STORE, S_DONE, S_HALT
  } state_e;

  state_e        state_q, state_d, load_next;
  logic [AW-1:0] pc_q, pc_d, epc_q, epc_d, dst_q, dst_d, sa_q, sa_d, sb_q, sb_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, res_q, res_d, wdata_q, wdata_d;
  logic [7:0]    ir_q, ir_d;
  logic [2:0]    pend_q, pend_d;
  logic [1:0]    k_q, k_d;
  logic          z_q, z_d, c_q, c_d, ie_q, ie_d;
  logic          req_q, req_d, we_q, we_d;
  logic          retire_q, retire_d, halted_q, halted_d, illegal_q, illegal_d;

  logic [3:0]    op;
  logic          fd, fa, fb, cz, alu_op, alu_c;
  logic [2:0]    ins_len, pick;
  logic [AW-1:0] pc_next, opnd_addr, rd_addr;
  logic [DW-1:0] alu_res;
  logic [DW:0]   sum;

  assign op        = ir_q[7:4];
  assign fd        = ir_q[3];
  assign fa        = ir_q[2];
  assign fb        = ir_q[1];
  assign cz        = ir_q[0];
  assign ins_len   = 3'd1 + 3'(fd) + 3'(fa) + 3'(fb);
  assign pc_next   = pc_q + AW'(ins_len);
  assign opnd_addr = pc_q + AW'(k_q);
  assign rd_addr   = AW'(mem_rdata);
  assign alu_op    = ((op >= OP_ADD) && (op <= OP_MOV)) || (op == OP_ADC);
  // Operand words arrive in dst, srcA, srcB order: fill the highest pending field.
  assign pick      = pend_q[2] ? 3'b100 : (pend_q[1] ? 3'b010 : 3'b001);

  always_comb begin
    if (fa && (op != OP_JMP)) load_next = S_LOADA;
    else if (fb)              load_next = S_LOADB;
    else                      load_next = S_EXEC;
  end

  always_comb begin
    alu_res = '0;
    alu_c   = c_q;
    sum     = '0;
    case (op)
      OP_ADD, OP_ADC: begin
        sum     = {1'b0, a_q} + {1'b0, b_q} + (DW+1)'(c_q & (op == OP_ADC));
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      OP_SUB: begin
        alu_res = a_q - b_q;
        alu_c   = (a_q < b_q);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOT:  alu_res = ~a_q;
      OP_SHL:  alu_res = a_q << b_q[SHW-1:0];
      OP_SHR:  alu_res = a_q >> b_q[SHW-1:0];
      OP_SRA:  alu_res = $unsigned($signed(a_q) >>> b_q[SHW-1:0]);
      OP_MOV:  alu_res = a_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;  pc_d = pc_q;    epc_d = epc_q;  z_d = z_q;     c_d = c_q;
    ie_d    = ie_q;     ir_d = ir_q;    pend_d = pend_q; k_d = k_q;
    dst_d   = dst_q;    sa_d = sa_q;    sb_d = sb_q;    a_d = a_q;     b_d = b_q;
    res_d   = res_q;    req_d = req_q;  we_d = we_q;    addr_d = addr_q;
    wdata_d = wdata_q;  retire_d = 1'b0; illegal_d = 1'b0; halted_d = halted_q;

    case (state_q)
      S_INIT: begin
        if (irq && ie_q) begin
          epc_d = pc_q;
          pc_d  = IRQ_VEC;
          ie_d  = 1'b0;
        end else begin
          state_d = S_IFETCH;
        end
      end
      S_IFETCH: begin
        if (!req_q) begin
          req_d = 1'b1; we_d = 1'b0; addr_d = pc_q;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          ir_d    = mem_rdata[DW-1 -: 8];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = '0; b_d = '0; dst_d = '0; sa_d = '0; sb_d = '0;
        pend_d = {fd, fa, fb};
        k_d    = 2'd1;
        if (cz && !z_q) begin
          pc_d     = pc_next;
          retire_d = 1'b1;
          state_d  = S_INIT;
        end else if ({fd, fa, fb} != 3'b000) begin
          state_d = S_OPFETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_OPFETCH: begin
        if (!req_q) begin
          req_d = 1'b1; we_d = 1'b0; addr_d = opnd_addr;
        end else if (mem_ack) begin
          req_d  = 1'b0;
          k_d    = k_q + 2'd1;
          pend_d = pend_q & ~pick;
          if (pick[2])      dst_d = rd_addr;
          else if (pick[1]) sa_d  = rd_addr;
          else              sb_d  = rd_addr;
          if ((pend_q & ~pick) == 3'b000) state_d = load_next;
        end
      end
      S_LOADA: begin
        if (!req_q) begin
          req_d = 1'b1; we_d = 1'b0; addr_d = sa_q;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          a_d     = mem_rdata;
          state_d = fb ? S_LOADB : S_EXEC;
        end
      end
      S_LOADB: begin
        if (!req_q) begin
          req_d = 1'b1; we_d = 1'b0; addr_d = sb_q;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          b_d     = mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (alu_op) begin
          res_d = alu_res;
          z_d   = (alu_res == '0);
        end
        if ((op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB)) c_d = alu_c;
        illegal_d = (op == OP_ILL);
        if (op == OP_JMP) begin
          pc_d = sa_q;
        end else if (op == OP_RETI) begin
          pc_d = epc_q;
          ie_d = 1'b1;
        end else begin
          pc_d = pc_next;
        end
        state_d = (fd && alu_op) ? S_STORE : S_DONE;
      end
      S_STORE: begin
        if (!req_q) begin
          req_d = 1'b1; we_d = 1'b1; addr_d = dst_q; wdata_d = res_q;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        retire_d = 1'b1;
        if (op == OP_HLT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          state_d = S_INIT;
        end
      end
      S_HALT:  ;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge W_RST) begin
    if (!W_RST) begin
      state_q <= S_INIT;  pc_q <= PC_RESET; epc_q <= '0;  z_q <= 1'b0;  c_q <= 1'b0;
      ie_q    <= 1'b1;    ir_q <= '0;       pend_q <= '0; k_q <= '0;
      dst_q   <= '0;      sa_q <= '0;       sb_q <= '0;   a_q <= '0;    b_q <= '0;
      res_q   <= '0;      req_q <= 1'b0;    we_q <= 1'b0; addr_q <= '0; wdata_q <= '0;
      retire_q <= 1'b0;   halted_q <= 1'b0; illegal_q <= 1'b0;
    end else begin
      state_q <= state_d; pc_q <= pc_d;     epc_q <= epc_d; z_q <= z_d; c_q <= c_d;
      ie_q    <= ie_d;    ir_q <= ir_d;     pend_q <= pend_d; k_q <= k_d;
      dst_q   <= dst_d;   sa_q <= sa_d;     sb_q <= sb_d;   a_q <= a_d; b_q <= b_d;
      res_q   <= res_d;   req_q <= req_d;   we_q <= we_d;   addr_q <= addr_d; wdata_q <= wdata_d;
      retire_q <= retire_d; halted_q <= halted_d; illegal_q <= illegal_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign retire    = retire_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mm_core.sv
`default_nettype none
`timescale 1ns/1ps
// ==========================================================================
// tb_cpu_mm_core : directed and randomized checks of cpu_mm_core against an
//                  instruction-level reference model.  Revision 1.0
// ==========================================================================
module tb_cpu_mm_core;
  localparam int            DW      = 32;
  localparam int            AW      = 32;
  localparam logic [AW-1:0] IRQ_VEC = 32'h10;

  logic          clk = 1'b0;
  logic          W_RST = 1'b0;
  logic          irq = 1'b0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_req, mem_we, retire, halted, illegal;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  always #5 clk = ~clk;

  cpu_mm_core #(.DW(DW), .AW(AW), .PC_RESET(32'h0), .IRQ_VEC(IRQ_VEC)) dut (
    .clk(clk), .W_RST(W_RST), .irq(irq),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .retire(retire), .halted(halted), .illegal(illegal)
  );

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } acc_t;
  acc_t        dut_log[$];
  acc_t        exp_log[$];
  logic [31:0] mem [0:255];
  logic [31:0] mm  [0:255];
  int  n_checks = 0, n_pass = 0;
  int  retire_cnt = 0, illegal_cnt = 0, stab_err = 0;
  bit  rand_wait = 0;
  int  fixed_wait = 0;

  // Memory slave: random or fixed wait states, access applied when ack is raised.
  initial begin : responder
    bit   busy;
    int   wc;
    acc_t cap;
    busy = 0; wc = 0; cap = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_req !== 1'b1) busy = 0;
      else begin
        if (!busy) begin
          busy = 1;
          cap  = {mem_we, mem_addr, mem_wdata};
          wc   = rand_wait ? int'($urandom_range(0, 5)) : fixed_wait;
        end else if (cap !== {mem_we, mem_addr, mem_wdata}) stab_err++;
        if (wc == 0) begin
          if (mem_we) begin
            mem[mem_addr[7:0]] = mem_wdata;
            dut_log.push_back({1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = mem[mem_addr[7:0]];
            dut_log.push_back({1'b0, mem_addr, mem_rdata});
          end
          mem_ack = 1'b1;
          busy    = 0;
        end else wc--;
      end
    end
  end

  initial begin : pulse_counter
    forever begin
      @(negedge clk);
      if (retire === 1'b1)  retire_cnt++;
      if (illegal === 1'b1) illegal_cnt++;
    end
  end

  function automatic logic [31:0] ins(input int op, input bit fd, input bit fa, input bit fb, input bit cz);
    return {4'(op), fd, fa, fb, cz, 24'h0};
  endfunction

  task automatic ex(input bit we, input int a, input logic [31:0] d = 32'h0);
    exp_log.push_back({we, 32'(a), d});
  endtask

  function automatic int first_diff(input bit cmp_rd);
    int n;
    n = (dut_log.size() < exp_log.size()) ? dut_log.size() : exp_log.size();
    for (int i = 0; i < n; i++)
      if (dut_log[i].we !== exp_log[i].we || dut_log[i].addr !== exp_log[i].addr ||
          ((exp_log[i].we || cmp_rd) && dut_log[i].data !== exp_log[i].data)) return i;
    if (dut_log.size() != exp_log.size()) return n;
    return -1;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    exp_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    W_RST = 1'b0; irq = 1'b0;
    repeat (3) @(negedge clk);
    dut_log.delete(); retire_cnt = 0; illegal_cnt = 0; stab_err = 0;
    W_RST = 1'b1;
  endtask

  task automatic run_to_halt(input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (halted === 1'b1) begin ok = 1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bit seen;
    clear_mem();
    W_RST = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({mem_req, mem_we, retire, halted, illegal} !== 5'b0)
      $display("FAIL reset_ctrl: got req/we/ret/halt/ill=%b want 00000", {mem_req, mem_we, retire, halted, illegal}); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL reset_bus: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); else n_pass++;
    W_RST = 1'b1; seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (mem_req === 1'b1) begin seen = 1; break; end end
    n_checks++; if (!seen || mem_addr !== 32'h0 || mem_we !== 1'b0)
      $display("FAIL reset_first_fetch: got seen=%0d addr=%h we=%b want 1/0/0", seen, mem_addr, mem_we); else n_pass++;
  endtask

  task automatic test_add();
    bit ok; int d;
    clear_mem(); rand_wait = 0; fixed_wait = 0;
    mem[0] = ins(1, 1, 1, 1, 0); mem[1] = 20; mem[2] = 21; mem[3] = 22;
    mem[4] = ins(10, 1, 1, 0, 1); mem[5] = 30; mem[6] = 21; mem[7] = ins(13, 0, 0, 0, 0);
    mem[21] = 5; mem[22] = 7;
    ex(0, 0); ex(0, 1); ex(0, 2); ex(0, 3); ex(0, 21); ex(0, 22); ex(1, 20, 12); ex(0, 4); ex(0, 7);
    do_reset(); run_to_halt(500, ok);
    n_checks++; if (!ok) $display("FAIL add_halt: got halted=0 want 1"); else n_pass++;
    n_checks++; if (mem[20] !== 32'd12) $display("FAIL add_store: got %0d want 12", mem[20]); else n_pass++;
    d = first_diff(0);
    n_checks++; if (d != -1) $display("FAIL add_trace: first difference at access %0d (got %0d accesses, want %0d)", d, dut_log.size(), exp_log.size()); else n_pass++;
    n_checks++; if (retire_cnt != 3) $display("FAIL add_retire: got %0d want 3", retire_cnt); else n_pass++;
  endtask

  task automatic test_cond();
    bit ok; int d;
    clear_mem(); rand_wait = 0; fixed_wait = 1;
    mem[0] = ins(2, 1, 1, 1, 0); mem[1] = 20; mem[2] = 21; mem[3] = 22;
    mem[4] = ins(10, 1, 1, 0, 1); mem[5] = 30; mem[6] = 21;
    mem[7] = ins(1, 1, 1, 1, 1); mem[8] = 31; mem[9] = 21; mem[10] = 22;
    mem[11] = ins(13, 0, 0, 0, 0);
    mem[20] = 55; mem[21] = 9; mem[22] = 9; mem[31] = 77;
    ex(0, 0); ex(0, 1); ex(0, 2); ex(0, 3); ex(0, 21); ex(0, 22); ex(1, 20, 0);
    ex(0, 4); ex(0, 5); ex(0, 6); ex(0, 21); ex(1, 30, 9); ex(0, 7); ex(0, 11);
    do_reset(); run_to_halt(500, ok);
    d = first_diff(0);
    n_checks++; if (!ok || d != -1) $display("FAIL cond_trace: halted=%0d first difference at access %0d (got %0d accesses, want %0d)", ok, d, dut_log.size(), exp_log.size()); else n_pass++;
    n_checks++; if (mem[20] !== 32'd0 || mem[30] !== 32'd9 || mem[31] !== 32'd77)
      $display("FAIL cond_mem: got m20=%0d m30=%0d m31=%0d want 0/9/77", mem[20], mem[30], mem[31]); else n_pass++;
    n_checks++; if (retire_cnt != 4) $display("FAIL cond_retire: got %0d want 4", retire_cnt); else n_pass++;
  endtask

  task automatic test_carry();
    bit ok;
    clear_mem(); rand_wait = 0; fixed_wait = 0;
    mem[0] = ins(1, 1, 1, 1, 0);  mem[1] = 20; mem[2] = 21; mem[3] = 22;
    mem[4] = ins(10, 1, 1, 0, 1); mem[5] = 26; mem[6] = 21;
    mem[7] = ins(14, 1, 1, 1, 0); mem[8] = 23; mem[9] = 24; mem[10] = 25;
    mem[11] = ins(13, 0, 0, 0, 0);
    mem[20] = 5; mem[21] = 32'hFFFF_FFFF; mem[22] = 1; mem[23] = 9;
    do_reset(); run_to_halt(500, ok);
    n_checks++; if (!ok || mem[20] !== 32'd0) $display("FAIL carry_add: got halted=%0d m20=%h want 1/0", ok, mem[20]); else n_pass++;
    n_checks++; if (mem[26] !== 32'hFFFF_FFFF) $display("FAIL carry_zflag: got m26=%h want ffffffff", mem[26]); else n_pass++;
    n_checks++; if (mem[23] !== 32'd1) $display("FAIL carry_adc: got %0d want 1", mem[23]); else n_pass++;
  endtask

  task automatic test_irq();
    bit ok, seen; int d;
    clear_mem(); rand_wait = 0; fixed_wait = 0;
    mem[0] = ins(1, 1, 1, 1, 0); mem[1] = 20; mem[2] = 21; mem[3] = 22;
    mem[4] = ins(13, 0, 0, 0, 0); mem[16] = ins(12, 0, 0, 0, 0);
    mem[21] = 5; mem[22] = 7;
    ex(0, 0); ex(0, 1); ex(0, 2); ex(0, 3); ex(0, 21); ex(0, 22); ex(1, 20, 12); ex(0, 16); ex(0, 4);
    do_reset(); seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (mem_req === 1'b1) begin seen = 1; break; end end
    irq = 1'b1; ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (irq && dut_log.size() > 0 && dut_log[dut_log.size()-1].addr == 32'(IRQ_VEC)) irq = 1'b0;
      if (halted === 1'b1) begin ok = 1; break; end
    end
    irq = 1'b0;
    repeat (2) @(negedge clk);
    d = first_diff(0);
    n_checks++; if (!seen || !ok || d != -1) $display("FAIL irq_trace: req=%0d halted=%0d first difference at access %0d (got %0d accesses, want %0d)", seen, ok, d, dut_log.size(), exp_log.size()); else n_pass++;
    n_checks++; if (retire_cnt != 3 || mem[20] !== 32'd12) $display("FAIL irq_retire: got retire=%0d m20=%0d want 3/12", retire_cnt, mem[20]); else n_pass++;
  endtask

  // Instruction-level interpreter over mm[]; builds the expected access list.
  task automatic model_run(output int n_ret, output int n_ill);
    logic [31:0] pc, ir, a, b, r, dst, sa, sb, epc;
    bit z, c, ie, fd, fa, fb, cz, alu;
    int op, len, k;
    longint s;
    n_ret = 0; n_ill = 0; pc = 0; epc = 0; z = 0; c = 0; ie = 1;
    exp_log.delete();
    for (int step = 0; step < 200; step++) begin
      ir = mm[pc[7:0]]; exp_log.push_back({1'b0, pc, ir});
      op = int'(ir[31:28]); fd = ir[27]; fa = ir[26]; fb = ir[25]; cz = ir[24];
      len = 1 + int'(fd) + int'(fa) + int'(fb);
      if (cz && !z) begin pc = pc + 32'(len); n_ret++; continue; end
      k = 1; dst = 0; sa = 0; sb = 0; a = 0; b = 0;
      if (fd) begin dst = mm[8'(pc + 32'(k))]; exp_log.push_back({1'b0, pc + 32'(k), dst}); k++; end
      if (fa) begin sa  = mm[8'(pc + 32'(k))]; exp_log.push_back({1'b0, pc + 32'(k), sa});  k++; end
      if (fb) begin sb  = mm[8'(pc + 32'(k))]; exp_log.push_back({1'b0, pc + 32'(k), sb});  k++; end
      if (fa && op != 11) begin a = mm[sa[7:0]]; exp_log.push_back({1'b0, sa, a}); end
      if (fb)             begin b = mm[sb[7:0]]; exp_log.push_back({1'b0, sb, b}); end
      alu = (op >= 1 && op <= 10) || op == 14;
      r = 0;
      case (op)
        1:  begin s = longint'(a) + longint'(b); r = s[31:0]; c = s[32]; end
        2:  begin r = a - b; c = (a < b); end
        3:  r = a & b;
        4:  r = a | b;
        5:  r = a ^ b;
        6:  r = ~a;
        7:  r = a << b[4:0];
        8:  r = a >> b[4:0];
        9:  r = $signed(a) >>> b[4:0];
        10: r = a;
        14: begin s = longint'(a) + longint'(b) + longint'(c); r = s[31:0]; c = s[32]; end
        default: r = 0;
      endcase
      if (alu) z = (r == 0);
      if (op == 15) n_ill++;
      if (op == 11) pc = sa;
      else if (op == 12) begin pc = epc; ie = 1; end
      else pc = pc + 32'(len);
      if (fd && alu) begin mm[dst[7:0]] = r; exp_log.push_back({1'b1, dst, r}); end
      n_ret++;
      if (op == 13) break;
    end
  endtask

  task automatic test_random();
    int ops[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 14, 15};
    int addr, op, len, n_ret, n_ill, d, bad;
    bit fd, fa, fb, ok;
    for (int p = 0; p < 4; p++) begin
      clear_mem(); rand_wait = (p != 0); fixed_wait = 0;
      for (int i = 64; i < 128; i++)
        case ($urandom_range(0, 3))
          0: mem[i] = 32'h0;
          1: mem[i] = 32'hFFFF_FFFF;
          default: mem[i] = $urandom();
        endcase
      addr = 0;
      for (int n = 0; n < 12; n++) begin
        op = ops[$urandom_range(0, 13)];
        fd = 1'($urandom); fa = 1'($urandom); fb = 1'($urandom);
        if (op == 11) fa = 1;
        len = 1 + int'(fd) + int'(fa) + int'(fb);
        mem[addr] = ins(op, fd, fa, fb, 1'($urandom));
        d = addr + 1;
        if (fd) begin mem[d] = 32'($urandom_range(64, 127)); d++; end
        if (fa) begin mem[d] = (op == 11) ? 32'(addr + len) : 32'($urandom_range(64, 127)); d++; end
        if (fb) begin mem[d] = 32'($urandom_range(64, 127)); d++; end
        addr = addr + len;
      end
      mem[addr] = ins(13, 0, 0, 0, 0);
      for (int i = 0; i < 256; i++) mm[i] = mem[i];
      model_run(n_ret, n_ill);
      do_reset(); run_to_halt(20000, ok);
      d = first_diff(1);
      n_checks++; if (!ok || d != -1) $display("FAIL rand%0d_trace: halted=%0d first difference at access %0d (got %0d accesses, want %0d)", p, ok, d, dut_log.size(), exp_log.size()); else n_pass++;
      bad = -1;
      for (int i = 0; i < 256; i++) if (mem[i] !== mm[i] && bad < 0) bad = i;
      n_checks++; if (bad >= 0) $display("FAIL rand%0d_mem: word %0d got %h want %h", p, bad, mem[bad], mm[bad]); else n_pass++;
      n_checks++; if (retire_cnt != n_ret || illegal_cnt != n_ill) $display("FAIL rand%0d_pulses: got retire=%0d illegal=%0d want %0d/%0d", p, retire_cnt, illegal_cnt, n_ret, n_ill); else n_pass++;
      n_checks++; if (stab_err != 0) $display("FAIL rand%0d_stable: got %0d changes while req held want 0", p, stab_err); else n_pass++;
    end
  endtask

  task automatic test_halt_reset();
    bit seen, ok, saw_req;
    clear_mem(); rand_wait = 0; fixed_wait = 4;
    mem[0] = ins(1, 1, 1, 1, 0); mem[1] = 20; mem[2] = 21; mem[3] = 22;
    mem[4] = ins(13, 0, 0, 0, 0);
    mem[20] = 32'hAA; mem[21] = 5; mem[22] = 7;
    do_reset(); seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_we === 1'b1) begin seen = 1; break; end
    end
    W_RST = 1'b0;
    #1;
    n_checks++; if (!seen || mem_req !== 1'b0 || mem_we !== 1'b0) $display("FAIL rst_mid_store: got store_seen=%0d req=%b we=%b want 1/0/0", seen, mem_req, mem_we); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (mem[20] !== 32'hAA) $display("FAIL rst_no_write: got m20=%h want aa", mem[20]); else n_pass++;
    W_RST = 1'b1; seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (mem_req === 1'b1) begin seen = 1; break; end end
    n_checks++; if (!seen || mem_addr !== 32'h0 || mem_we !== 1'b0) $display("FAIL rst_refetch: got seen=%0d addr=%h we=%b want 1/0/0", seen, mem_addr, mem_we); else n_pass++;
    run_to_halt(1000, ok);
    n_checks++; if (!ok || mem[20] !== 32'd12) $display("FAIL halt_result: got halted=%0d m20=%0d want 1/12", ok, mem[20]); else n_pass++;
    saw_req = 0;
    repeat (20) begin @(negedge clk); if (mem_req !== 1'b0) saw_req = 1; end
    n_checks++; if (saw_req || halted !== 1'b1) $display("FAIL halt_quiet: got req_seen=%0d halted=%b want 0/1", saw_req, halted); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_cond();
    test_carry();
    test_irq();
    test_random();
    test_halt_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
